// File: rtl/control_puertas_fsm.sv
// Door controller for an N_PISOS-floor car: opens on arrival/request, times travel and dwell,
// reopens on obstruction up to a limit, then force-closes with a buzzer.
module control_puertas_fsm #(
  parameter int unsigned N_PISOS         = 4,
  parameter int unsigned W_PISO          = 2,
  parameter int unsigned T_MOV           = 4,
  parameter int unsigned T_ABIERTA       = 8,
  parameter int unsigned MAX_REAPERTURAS = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [W_PISO-1:0]  i_piso_actual,
  input  logic               i_moviendose,
  input  logic [N_PISOS-1:0] i_solicitudes,
  input  logic [1:0]         i_boton,
  input  logic               i_sensor,
  output logic [1:0]         o_motor_puerta,
  output logic [1:0]         o_estado_puerta,
  output logic [N_PISOS-1:0] o_aviso,
  output logic [N_PISOS-1:0] o_atendido,
  output logic               o_trabajando,
  output logic               o_zumbador
);

  localparam int unsigned T_MAX = (T_MOV > T_ABIERTA) ? T_MOV : T_ABIERTA;
  localparam int unsigned W_TMR = $clog2(T_MAX) + 1;
  localparam int unsigned W_CNT = (MAX_REAPERTURAS > 0) ? $clog2(MAX_REAPERTURAS + 1) : 1;

  localparam logic [W_TMR-1:0] TMR_MOV = W_TMR'(T_MOV - 1);
  localparam logic [W_TMR-1:0] TMR_AB  = W_TMR'(T_ABIERTA - 1);
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(MAX_REAPERTURAS);

  typedef enum logic [2:0] {
    StCerrada,
    StAbriendo,
    StAbierta,
    StCerrando,
    StForzado
  } estado_e;

  estado_e              r_estado, w_estado_d;
  logic [W_TMR-1:0]     r_timer, w_timer_d;
  logic [W_CNT-1:0]     r_cnt, w_cnt_d;
  logic [1:0]           r_motor, w_motor_d;
  logic [1:0]           r_est, w_est_d;
  logic [N_PISOS-1:0]   r_aviso, w_aviso_d;
  logic [N_PISOS-1:0]   r_atendido, w_atendido_d;
  logic                 r_trab, w_trab_d;
  logic                 r_zumb, w_zumb_d;

  logic                 w_piso_ok;
  logic [N_PISOS-1:0]   w_onehot;
  logic                 w_sol_hit;
  logic                 w_abrir;
  logic                 w_cerrar;
  logic                 w_reabrir;

  // Floors beyond N_PISOS yield an all-zero one-hot, which blocks opening and pulses.
  assign w_piso_ok = (32'(i_piso_actual) < N_PISOS);
  assign w_onehot  = w_piso_ok ? (N_PISOS'(1) << i_piso_actual) : '0;
  assign w_sol_hit = |(i_solicitudes & w_onehot);
  assign w_abrir   = (i_boton == 2'b01);
  assign w_cerrar  = (i_boton == 2'b10);
  assign w_reabrir = i_sensor || w_abrir;

  always_comb begin
    w_estado_d   = r_estado;
    w_timer_d    = r_timer;
    w_cnt_d      = r_cnt;
    w_aviso_d    = '0;
    w_atendido_d = '0;
    if (i_moviendose && (r_estado inside {StAbriendo, StAbierta, StCerrando})) begin
      w_estado_d = StForzado;
      w_timer_d  = TMR_MOV;
    end else begin
      unique case (r_estado)
        StCerrada: begin
          if (!i_moviendose && w_piso_ok && (w_sol_hit || w_abrir)) begin
            w_estado_d = StAbriendo;
            w_timer_d  = TMR_MOV;
            w_cnt_d    = '0;
            w_aviso_d  = w_onehot;
          end
        end
        StAbriendo: begin
          if (r_timer == '0) begin
            w_estado_d   = StAbierta;
            w_timer_d    = TMR_AB;
            w_atendido_d = w_onehot;
          end else begin
            w_timer_d = r_timer - W_TMR'(1);
          end
        end
        StAbierta: begin
          if (w_reabrir) begin
            w_timer_d = TMR_AB;
          end else if (w_cerrar || (r_timer == '0)) begin
            w_estado_d = StCerrando;
            w_timer_d  = TMR_MOV;
          end else begin
            w_timer_d = r_timer - W_TMR'(1);
          end
        end
        StCerrando: begin
          if (w_reabrir) begin
            if (r_cnt < CNT_MAX) begin
              // Reopening only needs to undo the distance already closed.
              w_estado_d = StAbriendo;
              w_timer_d  = TMR_MOV - r_timer;
              w_cnt_d    = r_cnt + W_CNT'(1);
            end else begin
              w_estado_d = StForzado;
            end
          end else if (r_timer == '0) begin
            w_estado_d = StCerrada;
          end else begin
            w_timer_d = r_timer - W_TMR'(1);
          end
        end
        StForzado: begin
          if (r_timer == '0) begin
            w_estado_d = StCerrada;
          end else begin
            w_timer_d = r_timer - W_TMR'(1);
          end
        end
        default: begin
          w_estado_d = StCerrada;
          w_timer_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_motor_d = 2'b00;
    w_est_d   = 2'b00;
    w_trab_d  = 1'b1;
    w_zumb_d  = 1'b0;
    unique case (w_estado_d)
      StCerrada: begin
        w_trab_d = 1'b0;
      end
      StAbriendo: begin
        w_motor_d = 2'b01;
        w_est_d   = 2'b11;
      end
      StAbierta: begin
        w_est_d = 2'b01;
      end
      StCerrando: begin
        w_motor_d = 2'b10;
        w_est_d   = 2'b10;
      end
      StForzado: begin
        w_motor_d = 2'b10;
        w_est_d   = 2'b10;
        w_zumb_d  = 1'b1;
      end
      default: begin
        w_trab_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_estado   <= StCerrada;
      r_timer    <= '0;
      r_cnt      <= '0;
      r_motor    <= 2'b00;
      r_est      <= 2'b00;
      r_aviso    <= '0;
      r_atendido <= '0;
      r_trab     <= 1'b0;
      r_zumb     <= 1'b0;
    end else begin
      r_estado   <= w_estado_d;
      r_timer    <= w_timer_d;
      r_cnt      <= w_cnt_d;
      r_motor    <= w_motor_d;
      r_est      <= w_est_d;
      r_aviso    <= w_aviso_d;
      r_atendido <= w_atendido_d;
      r_trab     <= w_trab_d;
      r_zumb     <= w_zumb_d;
    end
  end

  assign o_motor_puerta  = r_motor;
  assign o_estado_puerta = r_est;
  assign o_aviso         = r_aviso;
  assign o_atendido      = r_atendido;
  assign o_trabajando    = r_trab;
  assign o_zumbador      = r_zumb;

endmodule

// File: tb/tb_control_puertas_fsm.sv
// Scoreboarded random bench: two controller configurations share one clock/reset, each with a
// cycle-count reference model; a monitor compares every registered output each cycle.
module tb_control_puertas_fsm;

  localparam int NA = 4, WA = 2, TMA = 4, TAA = 8, MA = 3;
  localparam int NB = 3, WB = 2, TMB = 2, TAB = 3, MB = 0;
  localparam int N_CYC = 3000;

  localparam int PH_CLOSED = 0, PH_OPENING = 1, PH_OPEN = 2, PH_CLOSING = 3, PH_FORCED = 4;

  typedef struct { int n; int tmov; int tab; int maxr; } cfg_t;
  // left = cycles still to spend in the current phase, counting the present one
  typedef struct { int phase; int left; int cnt; } mdl_t;
  typedef struct { int due; logic [21:0] v; } exp_t;

  logic clk, rst_n;

  logic [WA-1:0] a_piso;
  logic          a_mov, a_sen;
  logic [NA-1:0] a_sol, a_av, a_at;
  logic [1:0]    a_bot, a_motor, a_est;
  logic          a_trab, a_zumb;

  logic [WB-1:0] b_piso;
  logic          b_mov, b_sen;
  logic [NB-1:0] b_sol, b_av, b_at;
  logic [1:0]    b_bot, b_motor, b_est;
  logic          b_trab, b_zumb;

  control_puertas_fsm #(
    .N_PISOS(NA), .W_PISO(WA), .T_MOV(TMA), .T_ABIERTA(TAA), .MAX_REAPERTURAS(MA)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_piso_actual(a_piso), .i_moviendose(a_mov),
    .i_solicitudes(a_sol), .i_boton(a_bot), .i_sensor(a_sen),
    .o_motor_puerta(a_motor), .o_estado_puerta(a_est), .o_aviso(a_av), .o_atendido(a_at),
    .o_trabajando(a_trab), .o_zumbador(a_zumb)
  );

  control_puertas_fsm #(
    .N_PISOS(NB), .W_PISO(WB), .T_MOV(TMB), .T_ABIERTA(TAB), .MAX_REAPERTURAS(MB)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_piso_actual(b_piso), .i_moviendose(b_mov),
    .i_solicitudes(b_sol), .i_boton(b_bot), .i_sensor(b_sen),
    .o_motor_puerta(b_motor), .o_estado_puerta(b_est), .o_aviso(b_av), .o_atendido(b_at),
    .o_trabajando(b_trab), .o_zumbador(b_zumb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic logic [21:0] expv(input int phase, input logic [7:0] av, input logic [7:0] at);
    logic [1:0] m, e;
    logic       t, z;
    m = 2'b00; e = 2'b00; t = 1'b1; z = 1'b0;
    case (phase)
      PH_OPENING: begin m = 2'b01; e = 2'b11; end
      PH_OPEN:    begin e = 2'b01; end
      PH_CLOSING: begin m = 2'b10; e = 2'b10; end
      PH_FORCED:  begin m = 2'b10; e = 2'b10; z = 1'b1; end
      default:    t = 1'b0;
    endcase
    return {m, e, av, at, t, z};
  endfunction

  task automatic model_step(input cfg_t c, input mdl_t s, input int piso, input bit mov,
                            input logic [7:0] sol, input logic [1:0] bot, input bit sen,
                            input bit rn, output mdl_t ns, output logic [21:0] ev);
    logic [7:0] av, at;
    bit open_b, close_b, in_range;
    ns = s; av = '0; at = '0;
    open_b   = (bot == 2'b01);
    close_b  = (bot == 2'b10);
    in_range = (piso < c.n);
    if (!rn) begin
      ns.phase = PH_CLOSED; ns.left = 0; ns.cnt = 0;
    end else if (mov && (s.phase == PH_OPENING || s.phase == PH_OPEN || s.phase == PH_CLOSING)) begin
      ns.phase = PH_FORCED; ns.left = c.tmov;
    end else begin
      case (s.phase)
        PH_CLOSED:
          if (!mov && in_range && (sol[piso] || open_b)) begin
            ns.phase = PH_OPENING; ns.left = c.tmov; ns.cnt = 0; av[piso] = 1'b1;
          end
        PH_OPENING:
          if (s.left <= 1) begin
            ns.phase = PH_OPEN; ns.left = c.tab;
            if (in_range) at[piso] = 1'b1;
          end else ns.left = s.left - 1;
        PH_OPEN:
          if (sen || open_b) ns.left = c.tab;
          else if (close_b || s.left <= 1) begin ns.phase = PH_CLOSING; ns.left = c.tmov; end
          else ns.left = s.left - 1;
        PH_CLOSING:
          if (sen || open_b) begin
            if (s.cnt < c.maxr) begin
              // reopening lasts as many cycles as were spent closing, this one included
              ns.phase = PH_OPENING; ns.left = c.tmov - s.left + 1; ns.cnt = s.cnt + 1;
            end else ns.phase = PH_FORCED;
          end else if (s.left <= 1) ns.phase = PH_CLOSED;
          else ns.left = s.left - 1;
        PH_FORCED:
          if (s.left <= 1) ns.phase = PH_CLOSED;
          else ns.left = s.left - 1;
        default: ns.phase = PH_CLOSED;
      endcase
    end
    ev = expv(ns.phase, av, at);
  endtask

  task automatic rand_inputs(input int prof, input int maxpiso, output int piso_o, input int piso_i,
                             output bit mov, output logic [7:0] sol, output logic [1:0] bot,
                             output bit sen);
    int r;
    piso_o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, maxpiso)) : piso_i;
    sen = ($urandom_range(0, 99) < ((prof == 1) ? 35 : (prof == 2) ? 10 : 5));
    mov = ($urandom_range(0, 99) < ((prof == 2) ? 8 : 1));
    sol = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(0, 255)) : 8'h00;
    r = int'($urandom_range(0, 99));
    if (r < ((prof == 3) ? 20 : 5)) bot = 2'b01;
    else if (r < 32) bot = (r < 27) ? 2'b10 : 2'b11;
    else bot = 2'b00;
  endtask

  task automatic check(input string name, input exp_t e, input logic [21:0] act);
    vectors++;
    if (act !== e.v) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got motor/estado/aviso/atendido/trab/zumb=%b required %b",
               name, e.due, act, e.v);
    end
  endtask

  // Monitor: compare each expectation once the DUT edge it refers to has happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        e = qa.pop_front();
        check("dut_a", e, {a_motor, a_est, 8'(a_av), 8'(a_at), a_trab, a_zumb});
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
        e = qb.pop_front();
        check("dut_b", e, {b_motor, b_est, 8'(b_av), 8'(b_at), b_trab, b_zumb});
      end
    end
  end

  initial begin
    cfg_t ca, cb;
    mdl_t ma, mb, nma, nmb;
    logic [21:0] ev;
    logic [7:0] sa, sb;
    logic [1:0] ba, bb;
    bit mva, mvb, sea, seb, rn;
    int pa, pb, npa, npb, prof;

    ca = '{n: NA, tmov: TMA, tab: TAA, maxr: MA};
    cb = '{n: NB, tmov: TMB, tab: TAB, maxr: MB};
    ma = '{phase: PH_CLOSED, left: 0, cnt: 0};
    mb = ma;
    pa = 2; pb = 3;
    rst_n = 1'b0;
    a_piso = '0; a_mov = 1'b0; a_sol = '0; a_bot = 2'b00; a_sen = 1'b0;
    b_piso = '0; b_mov = 1'b0; b_sol = '0; b_bot = 2'b00; b_sen = 1'b0;

    for (int k = 0; k < N_CYC; k++) begin
      @(posedge clk);
      #1;
      if (k < 40) begin
        // directed opening: floor 2 call on A; out-of-range floor 3 on B, then floor 1
        rn = (k >= 2);
        mva = 1'b0; sea = 1'b0; ba = 2'b00;
        sa = (k == 3) ? 8'h04 : 8'h00;
        mvb = 1'b0; seb = 1'b0;
        pb = (k < 10) ? 3 : 1;
        sb = (k == 3 || k == 12) ? 8'h07 : 8'h00;
        bb = (k == 4) ? 2'b01 : 2'b00;
      end else begin
        prof = (k / 60) % 4;
        rn = ($urandom_range(0, 199) != 0);
        rand_inputs(prof, 3, npa, pa, mva, sa, ba, sea);
        rand_inputs((prof + 1) % 4, 3, npb, pb, mvb, sb, bb, seb);
        pa = npa; pb = npb;
      end
      rst_n = rn;
      a_piso = WA'(pa); a_mov = mva; a_sol = NA'(sa); a_bot = ba; a_sen = sea;
      b_piso = WB'(pb); b_mov = mvb; b_sol = NB'(sb); b_bot = bb; b_sen = seb;

      model_step(ca, ma, pa, mva, sa & 8'h0F, ba, sea, rn, nma, ev);
      qa.push_back('{due: cyc + 1, v: ev});
      ma = nma;
      model_step(cb, mb, pb, mvb, sb & 8'h07, bb, seb, rn, nmb, ev);
      qb.push_back('{due: cyc + 1, v: ev});
      mb = nmb;
    end

    repeat (3) @(posedge clk);
    #7;
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending expectations required 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
